// File: rtl/qdr_multiport_arb_if.sv
// Bundle of user-port and QDR-controller signals seen by the multiport arbiter.
// The master modport is the arbiter's view. The slave modport is the view of
// the user ports, the controller and the status consumers.
interface qdr_multiport_arb_if #(
    parameter int unsigned NUM_PORTS  = 4,
    parameter int unsigned DATA_WIDTH = 18,
    parameter int unsigned BW_WIDTH   = 2,
    parameter int unsigned ADDR_WIDTH = 21,
    parameter int unsigned TAG_DEPTH  = 16
);
    localparam int unsigned CntWidth = $clog2(TAG_DEPTH) + 1;

    // User ports
    logic [NUM_PORTS-1:0]              p_req;
    logic [NUM_PORTS-1:0]              p_rnw;
    logic [NUM_PORTS*ADDR_WIDTH-1:0]   p_addr;
    logic [NUM_PORTS*2*DATA_WIDTH-1:0] p_wr_data;
    logic [NUM_PORTS*2*BW_WIDTH-1:0]   p_wr_be;
    logic [NUM_PORTS-1:0]              p_ack;
    logic [2*DATA_WIDTH-1:0]           p_rd_data;
    logic [NUM_PORTS-1:0]              p_rd_dvld;

    // QDR controller side
    logic                              phy_rdy;
    logic                              usr_rd_strb;
    logic                              usr_wr_strb;
    logic [ADDR_WIDTH-1:0]             usr_addr;
    logic [2*DATA_WIDTH-1:0]           usr_wr_data;
    logic [2*BW_WIDTH-1:0]             usr_wr_be;
    logic [2*DATA_WIDTH-1:0]           usr_rd_data;
    logic                              usr_rd_dvld;

    // Status
    logic [CntWidth-1:0]               rd_outstanding;
    logic                              rd_underflow;

    modport master (
        input  p_req, p_rnw, p_addr, p_wr_data, p_wr_be, phy_rdy, usr_rd_data, usr_rd_dvld,
        output p_ack, p_rd_data, p_rd_dvld, usr_rd_strb, usr_wr_strb, usr_addr, usr_wr_data,
               usr_wr_be, rd_outstanding, rd_underflow
    );

    modport slave (
        output p_req, p_rnw, p_addr, p_wr_data, p_wr_be, phy_rdy, usr_rd_data, usr_rd_dvld,
        input  p_ack, p_rd_data, p_rd_dvld, usr_rd_strb, usr_wr_strb, usr_addr, usr_wr_data,
               usr_wr_be, rd_outstanding, rd_underflow
    );
endinterface

// File: rtl/qdr_multiport_arb.sv
// Round-robin arbiter that funnels N user ports onto one QDR controller.
// Read returns are routed back to the issuing port through an in-order tag FIFO.
module qdr_multiport_arb #(
    parameter int unsigned NUM_PORTS  = 4,
    parameter int unsigned DATA_WIDTH = 18,
    parameter int unsigned BW_WIDTH   = 2,
    parameter int unsigned ADDR_WIDTH = 21,
    parameter int unsigned TAG_DEPTH  = 16
) (
    input logic                 clk0,
    input logic                 reset_n,
    qdr_multiport_arb_if.master bus
);
    localparam int unsigned PortW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int unsigned PtrW  = $clog2(TAG_DEPTH);
    localparam int unsigned CntW  = PtrW + 1;
    localparam int unsigned UdW   = 2 * DATA_WIDTH;
    localparam int unsigned UbW   = 2 * BW_WIDTH;
    localparam logic [CntW-1:0] TagFull = CntW'(TAG_DEPTH);

    logic [PortW-1:0]     rr_q;      // first port examined in the next search
    logic [NUM_PORTS-1:0] eligible;
    logic                 gnt_vld;
    logic [PortW-1:0]     gnt_idx;
    int unsigned          cand;

    logic                 rd_strb_q, wr_strb_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [UdW-1:0]       wr_data_q;
    logic [UbW-1:0]       wr_be_q;

    logic [PortW-1:0]     tag_mem [TAG_DEPTH];
    logic [PtrW-1:0]      wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]      cnt_q;
    logic                 push, pop;

    logic [UdW-1:0]       rd_data_q;
    logic [NUM_PORTS-1:0] rd_dvld_q;
    logic                 underflow_q;

    // Per-port eligibility; reads are held back while every tag is in flight
    always_comb begin
        eligible = '0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            eligible[i] = reset_n & bus.p_req[i] & bus.phy_rdy &
                          (~bus.p_rnw[i] | (cnt_q < TagFull));
        end
    end

    // Round-robin search starting at rr_q
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        cand    = 0;
        for (int unsigned k = 0; k < NUM_PORTS; k++) begin
            cand = (32'(rr_q) + k) % NUM_PORTS;
            if (!gnt_vld && eligible[PortW'(cand)]) begin
                gnt_vld = 1'b1;
                gnt_idx = PortW'(cand);
            end
        end
    end

    // Combinational one-hot accept
    always_comb begin
        bus.p_ack = '0;
        if (gnt_vld) bus.p_ack[gnt_idx] = 1'b1;
    end

    assign push = gnt_vld & bus.p_rnw[gnt_idx];
    assign pop  = bus.usr_rd_dvld & (cnt_q != '0);

    // Register the accepted command for one cycle; payload holds when idle
    always_ff @(posedge clk0 or negedge reset_n) begin
        if (!reset_n) begin
            rr_q      <= '0;
            rd_strb_q <= 1'b0;
            wr_strb_q <= 1'b0;
            addr_q    <= '0;
            wr_data_q <= '0;
            wr_be_q   <= '0;
        end else begin
            rd_strb_q <= 1'b0;
            wr_strb_q <= 1'b0;
            if (gnt_vld) begin
                rr_q      <= (gnt_idx == PortW'(NUM_PORTS - 1)) ? '0 : gnt_idx + 1'b1;
                rd_strb_q <= bus.p_rnw[gnt_idx];
                wr_strb_q <= ~bus.p_rnw[gnt_idx];
                addr_q    <= bus.p_addr[gnt_idx*ADDR_WIDTH +: ADDR_WIDTH];
                wr_data_q <= bus.p_wr_data[gnt_idx*UdW +: UdW];
                wr_be_q   <= bus.p_wr_be[gnt_idx*UbW +: UbW];
            end
        end
    end

    // Tag storage; contents are meaningless outside the valid window so no reset
    always_ff @(posedge clk0) begin
        if (push) tag_mem[wr_ptr_q] <= gnt_idx;
    end

    // Tag FIFO pointers and occupancy; pointers wrap naturally (power-of-2 depth)
    always_ff @(posedge clk0 or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push && !pop)      cnt_q <= cnt_q + 1'b1;
            else if (pop && !push) cnt_q <= cnt_q - 1'b1;
        end
    end

    // Route returned read data to the port at the FIFO head; flag orphan returns
    always_ff @(posedge clk0 or negedge reset_n) begin
        if (!reset_n) begin
            rd_data_q   <= '0;
            rd_dvld_q   <= '0;
            underflow_q <= 1'b0;
        end else begin
            rd_dvld_q <= '0;
            if (pop) begin
                rd_data_q <= bus.usr_rd_data;
                rd_dvld_q <= NUM_PORTS'(1) << tag_mem[rd_ptr_q];
            end else if (bus.usr_rd_dvld) begin
                underflow_q <= 1'b1;
            end
        end
    end

    assign bus.usr_rd_strb    = rd_strb_q;
    assign bus.usr_wr_strb    = wr_strb_q;
    assign bus.usr_addr       = addr_q;
    assign bus.usr_wr_data    = wr_data_q;
    assign bus.usr_wr_be      = wr_be_q;
    assign bus.p_rd_data      = rd_data_q;
    assign bus.p_rd_dvld      = rd_dvld_q;
    assign bus.rd_outstanding = cnt_q;
    assign bus.rd_underflow   = underflow_q;
endmodule

// File: tb/tb_qdr_multiport_arb.sv
// Self-checking bench for qdr_multiport_arb: directed scenarios followed by
// randomized traffic, all compared against a queue-based reference model.
module tb_qdr_multiport_arb;
    localparam int NP = 4;
    localparam int DW = 18;
    localparam int BW = 2;
    localparam int AW = 21;
    localparam int TD = 16;
    localparam int UDW = 2 * DW;
    localparam int UBW = 2 * BW;

    logic clk0 = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk0 = ~clk0;

    qdr_multiport_arb_if #(
        .NUM_PORTS(NP), .DATA_WIDTH(DW), .BW_WIDTH(BW), .ADDR_WIDTH(AW), .TAG_DEPTH(TD)
    ) bus ();

    qdr_multiport_arb #(
        .NUM_PORTS(NP), .DATA_WIDTH(DW), .BW_WIDTH(BW), .ADDR_WIDTH(AW), .TAG_DEPTH(TD)
    ) dut (
        .clk0    (clk0),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    int             m_start;
    int             tagq[$];
    logic           m_under;
    logic           e_rd_strb, e_wr_strb;
    logic [AW-1:0]  e_addr;
    logic [UDW-1:0] e_wdata, e_rdata;
    logic [UBW-1:0] e_be;
    logic [NP-1:0]  e_dvld;
    logic [NP-1:0]  last_ack;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_start = 0;
        tagq.delete();
        m_under = 1'b0;
        e_rd_strb = 1'b0;
        e_wr_strb = 1'b0;
        e_addr = '0;
        e_wdata = '0;
        e_rdata = '0;
        e_be = '0;
        e_dvld = '0;
    endtask

    // Winner per the round-robin rules, or -1 when nobody is eligible
    function automatic int model_grant();
        for (int k = 0; k < NP; k++) begin
            int p;
            p = (m_start + k) % NP;
            if (bus.p_req[p] && bus.phy_rdy && (!bus.p_rnw[p] || tagq.size() < TD)) return p;
        end
        return -1;
    endfunction

    task automatic drive_idle();
        bus.p_req = '0;
        bus.p_rnw = '0;
        bus.p_addr = '0;
        bus.p_wr_data = '0;
        bus.p_wr_be = '0;
        bus.usr_rd_dvld = 1'b0;
        bus.usr_rd_data = '0;
    endtask

    task automatic set_cmd(input int p, input logic rnw, input logic [AW-1:0] a,
                           input logic [UDW-1:0] d, input logic [UBW-1:0] be);
        bus.p_req[p] = 1'b1;
        bus.p_rnw[p] = rnw;
        bus.p_addr[p*AW +: AW] = a;
        bus.p_wr_data[p*UDW +: UDW] = d;
        bus.p_wr_be[p*UBW +: UBW] = be;
    endtask

    task automatic check_regs();
        check_eq("usr_rd_strb", 64'(bus.usr_rd_strb), 64'(e_rd_strb));
        check_eq("usr_wr_strb", 64'(bus.usr_wr_strb), 64'(e_wr_strb));
        check_eq("usr_addr", 64'(bus.usr_addr), 64'(e_addr));
        check_eq("usr_wr_data", 64'(bus.usr_wr_data), 64'(e_wdata));
        check_eq("usr_wr_be", 64'(bus.usr_wr_be), 64'(e_be));
        check_eq("p_rd_dvld", 64'(bus.p_rd_dvld), 64'(e_dvld));
        check_eq("p_rd_data", 64'(bus.p_rd_data), 64'(e_rdata));
        check_eq("rd_outstanding", 64'(bus.rd_outstanding), 64'(tagq.size()));
        check_eq("rd_underflow", 64'(bus.rd_underflow), 64'(m_under));
    endtask

    // One clock: inputs were driven at the preceding negedge; returns at the next negedge
    task automatic step();
        int g;
        logic [NP-1:0] ea;
        #1;
        g = model_grant();
        ea = '0;
        if (g >= 0) ea[g] = 1'b1;
        last_ack = bus.p_ack;
        check_eq("p_ack", 64'(bus.p_ack), 64'(ea));
        e_rd_strb = 1'b0;
        e_wr_strb = 1'b0;
        e_dvld = '0;
        if (g >= 0) begin
            e_rd_strb = bus.p_rnw[g];
            e_wr_strb = !bus.p_rnw[g];
            e_addr = bus.p_addr[g*AW +: AW];
            e_wdata = bus.p_wr_data[g*UDW +: UDW];
            e_be = bus.p_wr_be[g*UBW +: UBW];
            m_start = (g + 1) % NP;
        end
        if (bus.usr_rd_dvld) begin
            if (tagq.size() > 0) begin
                e_dvld[tagq.pop_front()] = 1'b1;
                e_rdata = bus.usr_rd_data;
            end else begin
                m_under = 1'b1;
            end
        end
        if (g >= 0 && bus.p_rnw[g]) tagq.push_back(g);
        @(posedge clk0);
        #1;
        check_regs();
        @(negedge clk0);
    endtask

    initial begin
        logic [UDW-1:0] d;
        bus.phy_rdy = 1'b0;
        drive_idle();
        model_reset();
        #2;
        check_regs();
        check_eq("reset_ack", 64'(bus.p_ack), 64'd0);
        @(negedge clk0);
        reset_n = 1'b1;

        // Not calibrated: all ports requesting, nothing accepted
        for (int p = 0; p < NP; p++) set_cmd(p, 1'b0, AW'(p), UDW'(p), '1);
        step();
        check_eq("norpy_ack", 64'(last_ack), 64'd0);
        step();
        bus.phy_rdy = 1'b1;
        for (int p = 0; p < NP; p++) begin
            step();
            check_eq("rr_order", 64'(last_ack), 64'(1 << p));
        end

        // Port 2 write lands on the controller one cycle after accept
        drive_idle();
        set_cmd(2, 1'b0, AW'('h1234), UDW'(36'hA5A5A5A5A), UBW'('hF));
        step();
        check_eq("wr_ack", 64'(last_ack), 64'h4);
        check_eq("wr_strb", 64'(bus.usr_wr_strb), 64'd1);
        check_eq("wr_data", 64'(bus.usr_wr_data), 64'h A5A5A5A5A);
        drive_idle();
        step();
        check_eq("idle_hold", 64'(bus.usr_addr), 64'h1234);

        // Reads from ports 3, 1, 0 return in order
        set_cmd(3, 1'b1, AW'(3), '0, '0); step(); drive_idle();
        set_cmd(1, 1'b1, AW'(1), '0, '0); step(); drive_idle();
        set_cmd(0, 1'b1, AW'(0), '0, '0); step(); drive_idle();
        for (int r = 0; r < 3; r++) begin
            bus.usr_rd_dvld = 1'b1;
            bus.usr_rd_data = UDW'(36'h100 + r);
            step();
            check_eq("ret_port", 64'(bus.p_rd_dvld), (r == 0) ? 64'h8 : (r == 1) ? 64'h2 : 64'h1);
            check_eq("ret_data", 64'(bus.p_rd_data), 64'(36'h100 + r));
        end
        drive_idle();

        // Fill all tags; reads blocked, writes still pass
        for (int r = 0; r < TD; r++) begin
            set_cmd(1, 1'b1, AW'(r), '0, '0);
            step();
        end
        check_eq("full_cnt", 64'(bus.rd_outstanding), 64'(TD));
        set_cmd(2, 1'b0, AW'('h55), UDW'(7), UBW'(3));
        step();
        check_eq("full_wr_ack", 64'(last_ack), 64'h4);
        bus.p_req[2] = 1'b0;
        step();
        check_eq("full_rd_blk", 64'(last_ack), 64'd0);
        bus.usr_rd_dvld = 1'b1;
        step();
        bus.usr_rd_dvld = 1'b0;
        step();
        check_eq("refill_ack", 64'(last_ack), 64'h2);
        check_eq("refill_cnt", 64'(bus.rd_outstanding), 64'(TD));
        drive_idle();
        bus.usr_rd_dvld = 1'b1;
        for (int r = 0; r < TD; r++) begin
            bus.usr_rd_data = UDW'({$urandom, $urandom});
            step();
        end

        // Orphan return sets the sticky flag
        step();
        check_eq("underflow", 64'(bus.rd_underflow), 64'd1);
        check_eq("orphan_dvld", 64'(bus.p_rd_dvld), 64'd0);
        drive_idle();
        step();
        check_eq("underflow_sticky", 64'(bus.rd_underflow), 64'd1);

        // Asynchronous reset with reads in flight
        for (int r = 0; r < 5; r++) begin
            set_cmd(0, 1'b1, AW'(r), '0, '0);
            step();
        end
        check_eq("pre_rst_cnt", 64'(bus.rd_outstanding), 64'd5);
        bus.p_req = '1;
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        check_regs();
        check_eq("rst_ack", 64'(bus.p_ack), 64'd0);
        @(negedge clk0);
        reset_n = 1'b1;
        drive_idle();

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            bus.phy_rdy = ($urandom_range(0, 9) != 0);
            for (int p = 0; p < NP; p++) begin
                d = UDW'({$urandom, $urandom});
                bus.p_req[p] = $urandom_range(0, 1);
                bus.p_rnw[p] = ($urandom_range(0, 9) < 7);
                bus.p_addr[p*AW +: AW] = AW'($urandom);
                bus.p_wr_data[p*UDW +: UDW] = d;
                bus.p_wr_be[p*UBW +: UBW] = UBW'($urandom);
            end
            bus.usr_rd_dvld = ($urandom_range(0, 2) == 0);
            bus.usr_rd_data = UDW'({$urandom, $urandom});
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
